sprite_mem_arbiter: RTL and testbench
=====================================

// Module: sprite_mem_arbiter
// PURPOSE
//   Shares the single-port sprite image BRAM between two requesters:
//   - the VGA pixel-fetch path, which has fixed latency and priority;
//   - the host (manta bus) read/write port, which uses req/ack.
//   Sits between the VGA address calculation, the host bus bridge and the
//   image memory. Host traffic is slotted into cycles with no pixel fetch
//   (blanking, outside the sprite). A starvation guard forces a host slot
//   if the host has waited too long.
// PARAMETERS
//   ADDR_W        14  BRAM address width (128x128 sprite)
//   DATA_W        12  pixel width, RGB444
//   BRAM_LATENCY  2   cycles from mem_addr valid to mem_dout valid (>=1)
//   MAX_WAIT      255 host wait cycles before a forced grant (>=1)
// PORTS
//   clk          in   1       pixel clock; the only clock
//   rst_n        in   1       asynchronous, active-low reset
//   pix_req      in   1       pixel fetch requested this cycle
//   pix_addr     in   ADDR_W  pixel fetch address
//   pix_valid    out  1       pix_data valid, or slot was dropped
//   pix_data     out  DATA_W  fetched pixel; 0 when pix_miss
//   pix_miss     out  1       with pix_valid: slot was dropped for the host
//   host_req     in   1       host access request; held until host_ack
//   host_we      in   1       1 = write, 0 = read
//   host_addr    in   ADDR_W  host address
//   host_wdata   in   DATA_W  host write data
//   host_ack     out  1       1-cycle pulse: request accepted this edge
//   host_rvalid  out  1       1-cycle pulse: host_rdata valid
//   host_rdata   out  DATA_W  host read data
//   mem_addr     out  ADDR_W  BRAM address (registered)
//   mem_din      out  DATA_W  BRAM write data (registered)
//   mem_we       out  1       BRAM write enable (registered)
//   mem_dout     in   DATA_W  BRAM read data
//   starved      out  1       sticky: a forced grant has occurred
//   starved_clr  in   1       clears starved
// BEHAVIOUR
//   Reset: every output is 0. Host FSM goes to H_IDLE; wait_cnt=0; tag pipe=NONE.
//   Arbitration, each edge:
//   - host is eligible when host FSM is in H_IDLE and host_req=1;
//   - force = eligible && wait_cnt==MAX_WAIT;
//   - pix_req && !force: pixel grant. mem_addr<=pix_addr, mem_we<=0, tag PIX.
//   - pix_req && force: host grant; the pixel slot is dropped (tag MISS).
//   - otherwise, if eligible: host grant, host_ack=1. mem_addr<=host_addr,
//     mem_din<=host_wdata, mem_we<=host_we. Tag is HRD for a read, NONE for a write.
//   - no grant: mem_we<=0; mem_addr holds its value.
//   Tag pipe: 1+BRAM_LATENCY stages, {NONE,PIX,MISS,HRD}.
//   - A grant registered at edge k returns at cycle k+1+BRAM_LATENCY.
//   - PIX: pix_valid=1, pix_data=mem_dout.
//   - MISS: pix_valid=1, pix_miss=1, pix_data=0.
//   - HRD: host_rvalid=1, host_rdata=mem_dout.
//   - Outputs are driven from the last tag stage; each lasts exactly one cycle.
//   - Pixel latency is fixed at 1+BRAM_LATENCY whether a slot is granted or dropped.
//   Host FSM:
//   - H_IDLE -> H_RD on an acked read. H_RD -> H_IDLE in the host_rvalid cycle.
//   - An acked write stays in H_IDLE, so back-to-back writes are allowed.
//   - In H_RD, host_req is ignored: at most one read is outstanding.
//   wait_cnt (saturating):
//   - increments when eligible && not granted;
//   - clears on host grant or when host_req=0.
//   starved: set on a forced grant. starved_clr clears it; set wins if both occur in the same cycle.
//   Reset mid-read: the tag pipe is flushed; no host_rvalid is issued after reset.
//   The host must re-request.
//   Simultaneous pix_req and host_req with wait_cnt<MAX_WAIT: pixel wins, host waits.
// TESTING
//   1. pix_req=1 for 128 cycles, addrs 0..127, memory preloaded with mem[a]=a.
//      -> pix_valid at cycles 3..130 (BRAM_LATENCY=2), pix_data=0..127.
//   2. pix_req=0; host write 0x5A5 to addr 0x0010, then read addr 0x0010.
//      -> host_ack 1 cycle each; host_rvalid 3 cycles after the read ack; host_rdata=0x5A5.
//   3. pix_req=1 continuously; host_req read held, MAX_WAIT=4.
//      -> host_ack on the 5th cycle; that pixel slot returns pix_miss=1, pix_data=0.
//      -> starved=1 until starved_clr.
//   4. Host read acked, host_req held high through H_RD.
//      -> no second host_ack until the cycle after host_rvalid.
//   5. rst_n low 1 cycle after a host read ack.
//      -> all outputs 0 immediately; no host_rvalid afterwards; FSM in H_IDLE.
//   6. pix_req toggling 1,0,1,0 with host writes pending.
//      -> writes land only in the pix_req=0 cycles; every pixel returns pix_miss=0.

Source files
------------

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
//   Shares the single-port sprite image BRAM between the VGA pixel-fetch path
//   (fixed latency, priority) and the host bus read/write port (req/ack).
//   Host accesses are slotted into cycles without a pixel fetch. If the host
//   has waited MAX_WAIT cycles, a host slot is forced and that pixel slot is
//   returned as a miss with the same fixed latency.
//
// Ports
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   pix_req/pix_addr           pixel fetch request
//   pix_valid/pix_data/pix_miss  pixel return, 1+BRAM_LATENCY cycles later
//   host_req/host_we/host_addr/host_wdata  host request, held until host_ack
//   host_ack                   pulse: request accepted at this edge
//   host_rvalid/host_rdata     pulse: host read data
//   mem_addr/mem_din/mem_we    registered BRAM controls
//   mem_dout                   BRAM read data, BRAM_LATENCY after mem_addr
//   starved/starved_clr        sticky forced-grant flag and its clear
module sprite_mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 12,
  parameter int BRAM_LATENCY = 2,
  parameter int MAX_WAIT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_miss,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              starved,
  input  logic              starved_clr
);

  typedef enum logic [1:0] {TAG_NONE, TAG_PIX, TAG_MISS, TAG_HRD} tag_t;

  // A forced host read shares its slot with the dropped pixel (tag MISS),
  // so the host-read return is carried as its own bit next to the tag.
  typedef struct packed {
    tag_t tag;
    logic host_rd;
  } slot_t;

  typedef enum logic {H_IDLE, H_RD} host_state_t;

  localparam int STAGES = 1 + BRAM_LATENCY;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  host_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  slot_t             pipe [STAGES];

  logic  eligible;
  logic  force_grant;
  logic  pix_grant;
  logic  host_grant;
  slot_t issue;
  slot_t retire;

  assign eligible    = (state == H_IDLE) && host_req;
  assign force_grant = eligible && (wait_cnt == WAIT_MAX);
  assign pix_grant   = pix_req && !force_grant;
  assign host_grant  = eligible && (force_grant || !pix_req);
  assign retire      = pipe[STAGES-1];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    issue = '0;
    if (pix_grant) begin
      issue.tag = TAG_PIX;
    end else if (host_grant) begin
      issue.host_rd = !host_we;
      if (pix_req)       issue.tag = TAG_MISS;
      else if (!host_we) issue.tag = TAG_HRD;
      else               issue.tag = TAG_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= H_IDLE;
      wait_cnt    <= '0;
      // The tag pipe is reset (unlike a data RAM) so an in-flight read
      // cannot produce a return after reset.
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_miss    <= 1'b0;
      host_ack    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
      starved     <= 1'b0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];

      // BRAM port: mem_addr/mem_din hold when nothing is granted.
      mem_we <= 1'b0;
      if (pix_grant) begin
        mem_addr <= pix_addr;
      end else if (host_grant) begin
        mem_addr <= host_addr;
        mem_din  <= host_wdata;
        mem_we   <= host_we;
      end
      host_ack <= host_grant;

      // Returns, one cycle each, from the last tag stage.
      pix_valid   <= (retire.tag == TAG_PIX) || (retire.tag == TAG_MISS);
      pix_miss    <= (retire.tag == TAG_MISS);
      pix_data    <= (retire.tag == TAG_PIX) ? mem_dout : '0;
      host_rvalid <= retire.host_rd;
      host_rdata  <= retire.host_rd ? mem_dout : '0;

      // Host FSM: at most one read outstanding; writes stay in H_IDLE.
      case (state)
        H_IDLE: if (host_grant && !host_we) state <= H_RD;
        H_RD:   if (retire.host_rd)         state <= H_IDLE;
        default:                            state <= H_IDLE;
      endcase

      if (host_grant || !host_req) wait_cnt <= '0;
      else if (eligible && (wait_cnt != WAIT_MAX)) wait_cnt <= wait_cnt + WAIT_W'(1);

      // Set wins over clear.
      if (force_grant)      starved <= 1'b1;
      else if (starved_clr) starved <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
module tb_sprite_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_req = 1'b0;
  logic [ADDR_W-1:0] pix_addr = '0;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_miss;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout = '0;
  logic              starved;
  logic              starved_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  sprite_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_LATENCY(2), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_miss(pix_miss),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout),
    .starved(starved), .starved_clr(starved_clr)
  );

  always #5 clk = ~clk;

  // BRAM model, 2-cycle read latency. Unwritten words read back as their
  // own address (mem[a] = a).
  bit [DATA_W-1:0] mem     [1 << ADDR_W];
  bit              written [1 << ADDR_W];
  logic [DATA_W-1:0] rd1 = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_din;
      written[mem_addr] <= 1'b1;
    end
    rd1      <= written[mem_addr] ? mem[mem_addr] : mem_addr[DATA_W-1:0];
    mem_dout <= rd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pix_valid"},   32'(pix_valid),   0);
    check({tag, " pix_data"},    32'(pix_data),    0);
    check({tag, " pix_miss"},    32'(pix_miss),    0);
    check({tag, " host_ack"},    32'(host_ack),    0);
    check({tag, " host_rvalid"}, 32'(host_rvalid), 0);
    check({tag, " host_rdata"},  32'(host_rdata),  0);
    check({tag, " mem_addr"},    32'(mem_addr),    0);
    check({tag, " mem_din"},     32'(mem_din),     0);
    check({tag, " mem_we"},      32'(mem_we),      0);
    check({tag, " starved"},     32'(starved),     0);
  endtask

  // Host read with pix_req low: ack on the first edge, then a bounded wait
  // for host_rvalid.
  task automatic host_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    bit got;
    host_req = 1'b1; host_we = 1'b0; host_addr = addr;
    tick();
    check("rd ack", 32'(host_ack), 1);
    host_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (host_rvalid) got = 1'b1;
    end
    check("rd rvalid seen", 32'(got), 1);
    check("rd data", 32'(host_rdata), 32'(exp));
  endtask

  typedef struct {
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              exp_ack;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_pv;
    logic              exp_miss;
    logic [DATA_W-1:0] exp_pdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Pixel requests alternate with pending host writes; writes may only
    // take the pix_req=0 slots, pixels return 3 edges later without miss.
    vecs[0] = '{1'b1, 14'h200, 1'b1, 14'h300, 12'hA01, 1'b0, 1'b0, 14'h200, 1'b0, 1'b0, 12'h000};
    vecs[1] = '{1'b0, 14'h000, 1'b1, 14'h300, 12'hA01, 1'b1, 1'b1, 14'h300, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{1'b1, 14'h202, 1'b1, 14'h301, 12'hA02, 1'b0, 1'b0, 14'h202, 1'b0, 1'b0, 12'h000};
    vecs[3] = '{1'b0, 14'h000, 1'b1, 14'h301, 12'hA02, 1'b1, 1'b1, 14'h301, 1'b1, 1'b0, 12'h200};
    vecs[4] = '{1'b1, 14'h204, 1'b1, 14'h302, 12'hA03, 1'b0, 1'b0, 14'h204, 1'b0, 1'b0, 12'h000};
    vecs[5] = '{1'b0, 14'h000, 1'b1, 14'h302, 12'hA03, 1'b1, 1'b1, 14'h302, 1'b1, 1'b0, 12'h202};
    vecs[6] = '{1'b0, 14'h000, 1'b0, 14'h000, 12'h000, 1'b0, 1'b0, 14'h302, 1'b0, 1'b0, 12'h000};
    vecs[7] = '{1'b0, 14'h000, 1'b0, 14'h000, 12'h000, 1'b0, 1'b0, 14'h302, 1'b1, 1'b0, 12'h204};
    vecs[8] = '{1'b0, 14'h000, 1'b0, 14'h000, 12'h000, 1'b0, 1'b0, 14'h302, 1'b0, 1'b0, 12'h000};

    // Reset state.
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: streaming pixel fetch, data returns 3 edges after each request.
    for (int i = 0; i < 132; i++) begin
      pix_req  = (i < 128);
      pix_addr = ADDR_W'(i);
      tick();
      if (i >= 3 && i - 3 < 128) begin
        check("t1 pix_valid", 32'(pix_valid), 1);
        check("t1 pix_data",  32'(pix_data),  32'(i - 3));
        check("t1 pix_miss",  32'(pix_miss),  0);
      end else begin
        check("t1 pix_valid idle", 32'(pix_valid), 0);
      end
    end
    pix_req = 1'b0;

    // 2: host write then read of the same address.
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0010; host_wdata = 12'h5A5;
    tick();
    check("t2 wr ack",  32'(host_ack), 1);
    check("t2 mem_we",  32'(mem_we),   1);
    check("t2 mem_addr", 32'(mem_addr), 32'h10);
    check("t2 mem_din", 32'(mem_din),  32'h5A5);
    host_req = 1'b0;
    tick();
    check("t2 wr ack pulse", 32'(host_ack), 0);
    check("t2 mem_we pulse", 32'(mem_we),   0);
    host_req = 1'b1; host_we = 1'b0;
    tick();
    check("t2 rd ack", 32'(host_ack), 1);
    host_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t2 rvalid", 32'(host_rvalid), 32'(i == 3));
      if (i == 3) check("t2 rdata", 32'(host_rdata), 32'h5A5);
    end

    // 3: continuous pixels starve a held host read; forced on the 5th edge.
    for (int j = 1; j <= 12; j++) begin
      pix_req  = (j <= 9);
      pix_addr = ADDR_W'(32'h100 + j);
      host_req = (j <= 5); host_we = 1'b0; host_addr = 14'h0010;
      tick();
      check("t3 ack", 32'(host_ack), 32'(j == 5));
      check("t3 starved", 32'(starved), 32'(j >= 5));
      check("t3 rvalid", 32'(host_rvalid), 32'(j == 8));
      if (j >= 4 && j - 3 <= 9) begin
        check("t3 pix_valid", 32'(pix_valid), 1);
        check("t3 pix_miss",  32'(pix_miss),  32'(j == 8));
        check("t3 pix_data",  32'(pix_data),  (j == 8) ? 0 : 32'h100 + j - 3);
      end else begin
        check("t3 pix_valid idle", 32'(pix_valid), 0);
      end
      if (j == 8) check("t3 rdata", 32'(host_rdata), 32'h5A5);
    end
    check("t3 starved sticky", 32'(starved), 1);
    starved_clr = 1'b1;
    tick();
    starved_clr = 1'b0;
    check("t3 starved clr", 32'(starved), 0);

    // 4: host_req held through H_RD; second ack only after host_rvalid.
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t4 ack",    32'(host_ack),    32'(i == 1 || i == 5));
      check("t4 rvalid", 32'(host_rvalid), 32'(i == 4));
    end
    host_req = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      tick();
      check("t4 rvalid2", 32'(host_rvalid), 32'(i == 8));
    end

    // 5: reset one cycle after a read ack flushes the pending return.
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0010;
    tick();
    check("t5 ack", 32'(host_ack), 1);
    host_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("t5 reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5 no rvalid", 32'(host_rvalid), 0);
    end
    host_read(14'h0010, 12'h5A5);

    // 6: table-driven interleave of pixels and host writes.
    for (int v = 0; v < 9; v++) begin
      pix_req    = vecs[v].pix_req;
      pix_addr   = vecs[v].pix_addr;
      host_req   = vecs[v].host_req;
      host_we    = 1'b1;
      host_addr  = vecs[v].host_addr;
      host_wdata = vecs[v].host_wdata;
      tick();
      check($sformatf("t6[%0d] ack", v),       32'(host_ack),  32'(vecs[v].exp_ack));
      check($sformatf("t6[%0d] mem_we", v),    32'(mem_we),    32'(vecs[v].exp_we));
      check($sformatf("t6[%0d] mem_addr", v),  32'(mem_addr),  32'(vecs[v].exp_addr));
      check($sformatf("t6[%0d] pix_valid", v), 32'(pix_valid), 32'(vecs[v].exp_pv));
      check($sformatf("t6[%0d] pix_miss", v),  32'(pix_miss),  32'(vecs[v].exp_miss));
      check($sformatf("t6[%0d] pix_data", v),  32'(pix_data),  32'(vecs[v].exp_pdata));
    end
    host_read(14'h0300, 12'hA01);
    host_read(14'h0301, 12'hA02);
    host_read(14'h0302, 12'hA03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
